// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern engine (off / steady / blink / breathe) feeding the
// iCE40 RGB driver PWM inputs, with debounced active-low touch-pad override.
module led_pattern_ctrl #(
    parameter int NCH         = 3,
    parameter int PWM_BITS    = 8,
    parameter int STEP_DIV    = 18750,
    parameter int BLINK_TICKS = 640,
    parameter int DEB_CYCLES  = 48000,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    input  logic [NCH-1:0]      pad_n,
    output logic [NCH-1:0]      pwm_o,
    output logic [NCH-1:0]      pressed,
    output logic                tick_o
);

    localparam int PRE_W = $clog2(STEP_DIV);
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRE_W-1:0]    presc;
    logic                tick;

    mode_t               mode      [NCH];
    logic [PWM_BITS-1:0] duty      [NCH];
    logic [BLK_W-1:0]    blink_cnt [NCH];
    logic [NCH-1:0]      blink_state;
    logic [PWM_BITS-1:0] ramp      [NCH];
    logic [NCH-1:0]      ramp_down;
    logic [PWM_BITS-1:0] pattern   [NCH];
    logic [PWM_BITS-1:0] level     [NCH];
    logic [NCH-1:0]      wr_sel;

    logic [NCH-1:0]      pad_s1;
    logic [NCH-1:0]      pad_s2;
    logic [DEB_W-1:0]    deb_cnt   [NCH];

    assign tick   = (presc == PRE_LAST);
    assign tick_o = tick;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pwm_cnt <= '0;
            presc   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            presc   <= tick ? '0 : presc + 1'b1;
        end
    end

    // Out-of-range channel numbers match no channel, so such writes vanish.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_sel[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                mode[i]        <= MODE_OFF;
                duty[i]        <= '0;
                blink_cnt[i]   <= '0;
                blink_state[i] <= 1'b1;
                ramp[i]        <= '0;
                ramp_down[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_sel[i]) begin
                    mode[i]        <= mode_t'(cfg_mode);
                    duty[i]        <= cfg_duty;
                    blink_cnt[i]   <= '0;
                    blink_state[i] <= 1'b1;
                    ramp[i]        <= '0;
                    ramp_down[i]   <= 1'b0;
                end else if (tick) begin
                    if (mode[i] == MODE_BLINK) begin
                        if (blink_cnt[i] == BLK_LAST) begin
                            blink_cnt[i]   <= '0;
                            blink_state[i] <= ~blink_state[i];
                        end else begin
                            blink_cnt[i] <= blink_cnt[i] + 1'b1;
                        end
                    end
                    // Turning points spend one tick flipping direction, so peak and zero are held twice.
                    if (mode[i] == MODE_BREATHE) begin
                        if (!ramp_down[i]) begin
                            if (ramp[i] == duty[i]) ramp_down[i] <= 1'b1;
                            else                    ramp[i]      <= ramp[i] + 1'b1;
                        end else begin
                            if (ramp[i] == '0) ramp_down[i] <= 1'b0;
                            else               ramp[i]      <= ramp[i] - 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pattern[i] = '0;
            case (mode[i])
                MODE_ON:      pattern[i] = duty[i];
                MODE_BLINK:   pattern[i] = blink_state[i] ? duty[i] : '0;
                MODE_BREATHE: pattern[i] = ramp[i];
                default:      pattern[i] = '0;
            endcase
        end
    end

    // The pad override is applied at the comparator so a press reaches the pin one cycle after debounce.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pwm_o <= '0;
            for (int i = 0; i < NCH; i++) begin
                level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                level[i] <= pattern[i];
                pwm_o[i] <= ((pressed[i] ? {PWM_BITS{1'b1}} : level[i]) > pwm_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pad_s1  <= '1;
            pad_s2  <= '1;
            pressed <= '0;
            for (int i = 0; i < NCH; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            pad_s1 <= pad_n;
            pad_s2 <= pad_s1;
            for (int i = 0; i < NCH; i++) begin
                if (pad_s2[i] == ~pressed[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    pressed[i] <= ~pressed[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed self-checking bench for led_pattern_ctrl with small parameters so
// ticks, blink halves, ramps and debounce all fit in a few hundred clocks.
module tb_led_pattern_ctrl;

    localparam int NCH         = 3;
    localparam int PWM_BITS    = 4;
    localparam int STEP_DIV    = 4;
    localparam int BLINK_TICKS = 2;
    localparam int DEB_CYCLES  = 3;

    logic                clk      = 1'b0;
    logic                rstn     = 1'b0;
    logic                cfg_we   = 1'b0;
    logic [1:0]          cfg_ch   = '0;
    logic [1:0]          cfg_mode = '0;
    logic [PWM_BITS-1:0] cfg_duty = '0;
    logic [NCH-1:0]      pad_n    = '1;
    logic [NCH-1:0]      pwm_o;
    logic [NCH-1:0]      pressed;
    logic                tick_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [1:0]          ch;
        logic [1:0]          mode;
        logic [PWM_BITS-1:0] duty;
        int                  e0;
        int                  e1;
        int                  e2;
    } vec_t;

    vec_t vecs[9];
    int   blink_lvl[4];
    int   breathe_lvl[8];
    int   relight_exp[12];

    led_pattern_ctrl #(
        .NCH(NCH), .PWM_BITS(PWM_BITS), .STEP_DIV(STEP_DIV),
        .BLINK_TICKS(BLINK_TICKS), .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .pad_n(pad_n),
        .pwm_o(pwm_o), .pressed(pressed), .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    // cyc mirrors the free-running pwm counter: 0 on a reset edge, +1 on every other edge.
    always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] ch, input logic [1:0] mode, input logic [PWM_BITS-1:0] duty);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = mode;
        cfg_duty = duty;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic count_window(input int n, output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        repeat (n) begin
            step();
            c0 += int'(pwm_o[0]);
            c1 += int'(pwm_o[1]);
            c2 += int'(pwm_o[2]);
        end
    endtask

    task automatic align16();
        for (int k = 0; k < 17 && (cyc % 16) != 0; k++) step();
    endtask

    // Ticks applied by edge w+j for a write latched at an edge w = 1 (mod 4).
    function automatic int ticks_since(input int j);
        return (j < 3) ? 0 : ((j - 3) / 4 + 1);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0, c1, c2, lvl;

        vecs[0] = '{2'd0, 2'd1, 4'd5,  5,  0, 0};
        vecs[1] = '{2'd0, 2'd1, 4'd0,  0,  0, 0};
        vecs[2] = '{2'd0, 2'd1, 4'd15, 15, 0, 0};
        vecs[3] = '{2'd1, 2'd1, 4'd9,  15, 9, 0};
        vecs[4] = '{2'd2, 2'd1, 4'd1,  15, 9, 1};
        vecs[5] = '{2'd3, 2'd1, 4'd7,  15, 9, 1};
        vecs[6] = '{2'd1, 2'd0, 4'd12, 15, 0, 1};
        vecs[7] = '{2'd0, 2'd1, 4'd5,  5,  0, 1};
        vecs[8] = '{2'd2, 2'd0, 4'd0,  5,  0, 0};
        blink_lvl   = '{15, 15, 0, 0};
        breathe_lvl = '{0, 1, 2, 3, 3, 2, 1, 0};
        relight_exp = '{0, 0, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0};

        rstn  = 1'b0;
        pad_n = 3'b111;
        for (int k = 0; k < 5; k++) begin
            step();
            check_output("reset pwm_o", pwm_o, 0);
            check_output("reset pressed", pressed, 0);
            check_output("reset tick_o", tick_o, 0);
        end
        rstn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check_output($sformatf("tick_o after edge %0d", k), tick_o, (k % 4 == 3) ? 1 : 0);
        end

        for (int v = 0; v < 9; v++) begin
            apply_stimulus(vecs[v].ch, vecs[v].mode, vecs[v].duty);
            step();
            count_window(16, c0, c1, c2);
            check_output($sformatf("vec%0d ch0 ones", v), c0, vecs[v].e0);
            check_output($sformatf("vec%0d ch1 ones", v), c1, vecs[v].e1);
            check_output($sformatf("vec%0d ch2 ones", v), c2, vecs[v].e2);
        end

        // Blink on ch1, then a relighting write that lands on a tick edge.
        align16();
        apply_stimulus(2'd1, 2'd2, 4'd15);
        for (int r = 1; r <= 26; r++) begin
            step();
            if (r >= 2) begin
                lvl = blink_lvl[ticks_since(r - 2) % 4];
                check_output($sformatf("blink r%0d", r), pwm_o[1], (lvl > (r % 16)) ? 1 : 0);
            end
        end
        check_output("tick_o before coinciding write", tick_o, 1);
        apply_stimulus(2'd1, 2'd2, 4'd15);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            check_output($sformatf("relight r%0d", 27 + k), pwm_o[1], relight_exp[k]);
        end

        // Breathe on ch2 with peak 3, then peak 0.
        align16();
        apply_stimulus(2'd2, 2'd3, 4'd3);
        for (int r = 1; r <= 65; r++) begin
            step();
            if (r >= 2) begin
                lvl = breathe_lvl[ticks_since(r - 2) % 8];
                check_output($sformatf("breathe r%0d", r), pwm_o[2], (lvl > (r % 16)) ? 1 : 0);
            end
        end
        apply_stimulus(2'd2, 2'd3, 4'd0);
        step();
        count_window(32, c0, c1, c2);
        check_output("breathe duty0 ch2 ones", c2, 0);

        // Short glitch must not register; ch0 is ON with duty 5 here.
        pad_n = 3'b110;
        step();
        step();
        pad_n = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step();
            check_output("glitch pressed", pressed, 3'b000);
        end

        pad_n = 3'b110;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_output($sformatf("press edge %0d", k), pressed, (k == 5) ? 3'b001 : 3'b000);
        end
        step();
        count_window(16, c0, c1, c2);
        check_output("override ch0 ones", c0, 15);
        check_output("override ch2 ones", c2, 0);
        check_output("held pressed", pressed, 3'b001);

        pad_n = 3'b111;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_output($sformatf("release edge %0d", k), pressed, (k == 5) ? 3'b000 : 3'b001);
        end
        step();
        count_window(16, c0, c1, c2);
        check_output("after release ch0 ones", c0, 5);

        // Reset in the middle of a breathe ramp.
        apply_stimulus(2'd0, 2'd1, 4'd15);
        apply_stimulus(2'd2, 2'd3, 4'd15);
        repeat (40) step();
        rstn = 1'b0;
        step();
        check_output("mid reset pwm_o", pwm_o, 0);
        check_output("mid reset pressed", pressed, 0);
        check_output("mid reset tick_o", tick_o, 0);
        step();
        rstn = 1'b1;
        step();
        count_window(16, c0, c1, c2);
        check_output("post reset ch0 ones", c0, 0);
        check_output("post reset ch2 ones", c2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
